// File: rtl/fp_cmp_sched.sv
// Round-robin arbiter sharing one external FP compare unit (LT/LE/EQ) among NREQ requesters.
// Latency: grant in IDLE, CMP_LAT cycles in BUSY, then response; minimum CMP_LAT+2 cycles per request.
// Backpressure: one request in flight; req_ready is low until rsp_valid is accepted by rsp_ready.
module fp_cmp_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int CMP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 cmp_en,
    output logic [1:0]           cmp_op,
    output logic [31:0]          cmp_a,
    output logic [31:0]          cmp_b,
    input  logic [31:0]          cmp_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err
);

    localparam int CW = (CMP_LAT < 2) ? 1 : $clog2(CMP_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_cmp_op;
    logic [31:0]     r_cmp_a;
    logic [31:0]     r_cmp_b;
    logic [IDW-1:0]  r_rsp_id;
    logic            r_rsp_bit;
    logic            r_rsp_err;

    logic            w_gnt_vld;
    int              w_gnt_int;
    logic [IDW-1:0]  w_gnt_idx;
    logic [1:0]      w_gnt_op;
    logic [31:0]     w_gnt_a;
    logic [31:0]     w_gnt_b;
    logic            w_gnt_ill;
    logic            w_req_hs;
    logic            w_unused;

    // Only bit 0 of the comparator result carries the answer.
    assign w_unused = ^cmp_result[31:1];

    // Round-robin pick: nearest valid requester after the last grant, with wrap-around.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_int = 0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_gnt_vld = 1'b1;
                w_gnt_int = (int'(r_rr_ptr) + k) % NREQ;
            end
        end
    end

    assign w_gnt_idx = IDW'(w_gnt_int);
    assign w_gnt_op  = req_op[2*w_gnt_int +: 2];
    assign w_gnt_a   = req_a[32*w_gnt_int +: 32];
    assign w_gnt_b   = req_b[32*w_gnt_int +: 32];
    assign w_gnt_ill = (w_gnt_op == 2'b11);
    assign w_req_hs  = (r_state == S_IDLE) && w_gnt_vld;

    // Ready only toward the granted requester while idle; forced low during reset.
    always_comb begin
        req_ready = '0;
        if (w_req_hs && rst_n) begin
            req_ready[w_gnt_int] = 1'b1;
        end
    end

    assign cmp_en    = (r_state == S_BUSY);
    assign cmp_op    = r_cmp_op;
    assign cmp_a     = r_cmp_a;
    assign cmp_b     = r_cmp_b;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = {31'b0, r_rsp_bit};
    assign rsp_err   = r_rsp_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: illegal ops skip the comparator and answer directly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_hs) begin
                    w_state_nxt = w_gnt_ill ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the granted request, count comparator latency, capture the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= IDW'(NREQ - 1);
            r_cnt     <= '0;
            r_cmp_op  <= '0;
            r_cmp_a   <= '0;
            r_cmp_b   <= '0;
            r_rsp_id  <= '0;
            r_rsp_bit <= 1'b0;
            r_rsp_err <= 1'b0;
        end else if (w_req_hs) begin
            r_rr_ptr <= w_gnt_idx;
            r_rsp_id <= w_gnt_idx;
            r_cnt    <= CW'(CMP_LAT);
            if (w_gnt_ill) begin
                r_rsp_bit <= 1'b0;
                r_rsp_err <= 1'b1;
            end else begin
                // Comparator inputs only change for requests that will use them.
                r_cmp_op <= w_gnt_op;
                r_cmp_a  <= w_gnt_a;
                r_cmp_b  <= w_gnt_b;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_rsp_bit <= cmp_result[0];
                r_rsp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_cmp_sched.sv
module tb_fp_cmp_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance with CMP_LAT=1
    logic         rst1_n;
    logic [3:0]   rv1, rr1;
    logic [7:0]   op1;
    logic [127:0] a1, b1;
    logic         en1;
    logic [1:0]   cop1;
    logic [31:0]  ca1, cb1, res1;
    logic         rspv1, rsprdy1;
    logic [1:0]   rid1;
    logic [31:0]  rdat1;
    logic         rerr1;

    // Instance with CMP_LAT=3
    logic         rst3_n;
    logic [3:0]   rv3, rr3;
    logic [7:0]   op3;
    logic [127:0] a3, b3;
    logic         en3;
    logic [1:0]   cop3;
    logic [31:0]  ca3, cb3, res3;
    logic         rspv3, rsprdy3;
    logic [1:0]   rid3;
    logic [31:0]  rdat3;
    logic         rerr3;

    fp_cmp_sched #(.NREQ(4), .IDW(2), .CMP_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst1_n), .req_valid(rv1), .req_ready(rr1), .req_op(op1),
        .req_a(a1), .req_b(b1), .cmp_en(en1), .cmp_op(cop1), .cmp_a(ca1), .cmp_b(cb1),
        .cmp_result(res1), .rsp_valid(rspv1), .rsp_ready(rsprdy1), .rsp_id(rid1),
        .rsp_data(rdat1), .rsp_err(rerr1)
    );

    fp_cmp_sched #(.NREQ(4), .IDW(2), .CMP_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(rv3), .req_ready(rr3), .req_op(op3),
        .req_a(a3), .req_b(b3), .cmp_en(en3), .cmp_op(cop3), .cmp_a(ca3), .cmp_b(cb3),
        .cmp_result(res3), .rsp_valid(rspv3), .rsp_ready(rsprdy3), .rsp_id(rid3),
        .rsp_data(rdat3), .rsp_err(rerr3)
    );

    // Totally ordered key for non-NaN floats; +0 and -0 map to the same key.
    function automatic logic [31:0] fkey(input logic [31:0] x);
        if (x[30:0] == 31'd0) return 32'h8000_0000;
        if (x[31]) return ~x;
        return x | 32'h8000_0000;
    endfunction

    function automatic logic fcmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        ka = fkey(a);
        kb = fkey(b);
        case (op)
            2'b00:   return ka < kb;
            2'b01:   return ka <= kb;
            2'b10:   return ka == kb;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(0, 254));
        if ($urandom_range(0, 7) == 0) r[30:0] = 31'd0;
        return r;
    endfunction

    // Comparator models: answer is wrong until CMP_LAT cycles of enable, upper bits are junk.
    int ec1 = 0;
    int ec3 = 0;
    always @(posedge clk) ec1 <= en1 ? ec1 + 1 : 0;
    always @(posedge clk) ec3 <= en3 ? ec3 + 1 : 0;
    always_comb res1 = {ca1[31:1] ^ ~cb1[31:1], (ec1 >= 0) ? fcmp(cop1, ca1, cb1) : ~fcmp(cop1, ca1, cb1)};
    always_comb res3 = {ca3[31:1] ^ ~cb3[31:1], (ec3 >= 2) ? fcmp(cop3, ca3, cb3) : ~fcmp(cop3, ca3, cb3)};

    task automatic set_req1(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        rv1[i] = 1'b1;
        op1[2*i +: 2] = op;
        a1[32*i +: 32] = a;
        b1[32*i +: 32] = b;
    endtask

    task automatic set_req3(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        rv3[i] = 1'b1;
        op3[2*i +: 2] = op;
        a3[32*i +: 32] = a;
        b3[32*i +: 32] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset1();
        rst1_n = 1'b0;
        rv1 = '0;
        rsprdy1 = 1'b0;
        tick();
        rst1_n = 1'b1;
        tick();
    endtask

    // One complete request on instance 1; ok=0 if a bounded wait expired.
    task automatic run1(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [1:0] id, output logic [31:0] dat, output logic err, output bit ok);
        int t;
        ok = 1'b1;
        set_req1(i, op, a, b);
        rsprdy1 = 1'b1;
        #1;
        t = 0;
        while (!rr1[i] && t < 20) begin tick(); t++; end
        if (!rr1[i]) ok = 1'b0;
        tick();
        rv1[i] = 1'b0;
        t = 0;
        while (!rspv1 && t < 20) begin tick(); t++; end
        if (!rspv1) ok = 1'b0;
        id = rid1;
        dat = rdat1;
        err = rerr1;
        tick();
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst3_n = 1'b0;
        rv1 = 4'b1111; rv3 = '0; op1 = '0; op3 = '0;
        a1 = '0; b1 = '0; a3 = '0; b3 = '0;
        rsprdy1 = 1'b0; rsprdy3 = 1'b0;
        #12;
        n_tests++;
        if ({rr1, en1, cop1, ca1, cb1, rspv1, rid1, rdat1, rerr1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got rdy=%b en=%b rspv=%b id=%0d dat=%h err=%b, want all 0",
                     rr1, en1, rspv1, rid1, rdat1, rerr1);
        end
        n_tests++;
        if ({rr3, en3, cop3, ca3, cb3, rspv3, rid3, rdat3, rerr3} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat3: got rdy=%b en=%b rspv=%b id=%0d dat=%h err=%b, want all 0",
                     rr3, en3, rspv3, rid3, rdat3, rerr3);
        end
        rv1 = '0;
        @(posedge clk); #2;
        rst1_n = 1'b1; rst3_n = 1'b1;
        tick();
    endtask

    task automatic test_single_lt();
        set_req1(0, 2'b00, 32'hC143_3333, 32'h4160_0000);
        rsprdy1 = 1'b1;
        #1;
        n_tests++;
        if (rr1 !== 4'b0001) begin n_fail++; $display("FAIL lt_ready: got %b want 0001", rr1); end
        tick();
        rv1 = '0;
        n_tests++;
        if ({en1, cop1, ca1, cb1, rspv1} !== {1'b1, 2'b00, 32'hC143_3333, 32'h4160_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL lt_busy: got en=%b op=%b a=%h b=%h rspv=%b want en=1 op=00 a=c1433333 b=41600000 rspv=0",
                     en1, cop1, ca1, cb1, rspv1);
        end
        tick();
        n_tests++;
        if ({en1, rspv1, rid1, rdat1, rerr1} !== {1'b0, 1'b1, 2'd0, 32'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL lt_resp: got en=%b v=%b id=%0d dat=%h err=%b want en=0 v=1 id=0 dat=1 err=0",
                     en1, rspv1, rid1, rdat1, rerr1);
        end
        tick();
        n_tests++;
        if (rspv1 !== 1'b0) begin n_fail++; $display("FAIL lt_resp_drop: got rsp_valid=%b want 0", rspv1); end
    endtask

    task automatic test_equal();
        logic [1:0]  id;
        logic [31:0] dat;
        logic        err;
        bit          ok;
        logic [31:0] want [3];
        want[0] = 32'd0; want[1] = 32'd1; want[2] = 32'd1;
        for (int k = 0; k < 3; k++) begin
            run1(2, 2'(k), 32'h4020_0000, 32'h4020_0000, id, dat, err, ok);
            n_tests++;
            if (!ok || id !== 2'd2 || dat !== want[k] || err !== 1'b0) begin
                n_fail++;
                $display("FAIL equal_op%0d: got ok=%0d id=%0d dat=%h err=%b want ok=1 id=2 dat=%h err=0",
                         k, ok, id, dat, err, want[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        int t;
        logic [3:0] exp_rdy;
        reset1();
        for (int i = 0; i < 4; i++) set_req1(i, 2'b00, 32'h4200_0000, 32'h4334_0000);
        rsprdy1 = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'(1 << (k % 4));
            t = 0;
            while (rr1 == 4'b0 && t < 20) begin tick(); t++; end
            n_tests++;
            if (rr1 !== exp_rdy) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, rr1, exp_rdy); end
            tick();
            t = 0;
            while (!rspv1 && t < 20) begin tick(); t++; end
            n_tests++;
            if (!rspv1 || rid1 !== 2'(k % 4) || rdat1 !== 32'd1 || rerr1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_resp%0d: got v=%b id=%0d dat=%h err=%b want v=1 id=%0d dat=1 err=0",
                         k, rspv1, rid1, rdat1, rerr1, k % 4);
            end
            tick();
        end
        rv1 = '0;
        tick();
    endtask

    task automatic test_illegal();
        set_req1(1, 2'b11, 32'h3F80_0000, 32'h4000_0000);
        rsprdy1 = 1'b1;
        #1;
        n_tests++;
        if (rr1 !== 4'b0010) begin n_fail++; $display("FAIL ill_ready: got %b want 0010", rr1); end
        tick();
        rv1 = '0;
        n_tests++;
        if ({en1, rspv1, rid1, rdat1, rerr1} !== {1'b0, 1'b1, 2'd1, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL ill_resp: got en=%b v=%b id=%0d dat=%h err=%b want en=0 v=1 id=1 dat=0 err=1",
                     en1, rspv1, rid1, rdat1, rerr1);
        end
        tick();
        n_tests++;
        if ({en1, rspv1} !== 2'b00) begin n_fail++; $display("FAIL ill_after: got en=%b v=%b want 0 0", en1, rspv1); end
    endtask

    task automatic test_random();
        bit          pv [4];
        logic [1:0]  pop [4];
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        int last, g, t, any;
        logic [3:0]  exp_rdy;
        logic        exp_bit, exp_err;
        reset1();
        last = 3;
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        for (int n = 0; n < 40; n++) begin
            any = 0;
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1 || (i == 3 && any == 0 && !pv[0] && !pv[1] && !pv[2]))) begin
                    pv[i] = 1'b1;
                    pop[i] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                    pa[i] = rand_fp();
                    pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : rand_fp();
                    set_req1(i, pop[i], pa[i], pb[i]);
                end
                if (pv[i]) any++;
            end
            g = -1;
            for (int k = 4; k >= 1; k--) if (pv[(last + k) % 4]) g = (last + k) % 4;
            exp_rdy = 4'(1 << g);
            rsprdy1 = 1'b0;
            #1;
            n_tests++;
            if (rr1 !== exp_rdy) begin n_fail++; $display("FAIL rand_grant%0d: got %b want %b", n, rr1, exp_rdy); end
            tick();
            pv[g] = 1'b0;
            rv1[g] = 1'b0;
            last = g;
            t = 0;
            while (!rspv1 && t < 20) begin tick(); t++; end
            for (int d = $urandom_range(0, 2); d > 0; d--) tick();
            exp_err = (pop[g] == 2'b11);
            exp_bit = fcmp(pop[g], pa[g], pb[g]);
            n_tests++;
            if (!rspv1 || rid1 !== 2'(g) || rdat1 !== {31'b0, exp_bit} || rerr1 !== exp_err) begin
                n_fail++;
                $display("FAIL rand_resp%0d: got v=%b id=%0d dat=%h err=%b want v=1 id=%0d dat=%0d err=%b (op=%b a=%h b=%h)",
                         n, rspv1, rid1, rdat1, rerr1, g, exp_bit, exp_err, pop[g], pa[g], pb[g]);
            end
            rsprdy1 = 1'b1;
            tick();
        end
        rv1 = '0;
        rsprdy1 = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int c, enc;
        for (int i = 0; i < 4; i++) set_req3(i, 2'b00, 32'h4200_0000, 32'h4334_0000);
        rsprdy3 = 1'b0;
        #1;
        n_tests++;
        if (rr3 !== 4'b0001) begin n_fail++; $display("FAIL bp_ready: got %b want 0001", rr3); end
        tick();
        n_tests++;
        if ({ca3, cb3, cop3} !== {32'h4200_0000, 32'h4334_0000, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_operands: got a=%h b=%h op=%b want 42000000 43340000 00", ca3, cb3, cop3);
        end
        c = 0; enc = 0;
        while (!rspv3 && c < 10) begin
            if (en3) enc++;
            n_tests++;
            if (rr3 !== 4'b0) begin n_fail++; $display("FAIL bp_busy_ready: got %b want 0000", rr3); end
            tick();
            c++;
        end
        n_tests++;
        if (enc != 3 || c != 3) begin n_fail++; $display("FAIL bp_en_cycles: got en=%0d busy=%0d want 3 3", enc, c); end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if ({rspv3, rid3, rdat3, rerr3, rr3, en3} !== {1'b1, 2'd0, 32'd1, 1'b0, 4'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d dat=%h err=%b rdy=%b en=%b want 1 0 1 0 0000 0",
                         k, rspv3, rid3, rdat3, rerr3, rr3, en3);
            end
            tick();
        end
        rsprdy3 = 1'b1;
        tick();
        n_tests++;
        if ({rspv3, rr3} !== {1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL bp_next_grant: got v=%b rdy=%b want 0 0010", rspv3, rr3);
        end
        rv3 = '0;
        rsprdy3 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        set_req3(0, 2'b01, 32'h3F80_0000, 32'h3F80_0000);
        set_req3(3, 2'b00, 32'h3F80_0000, 32'h4000_0000);
        #1;
        n_tests++;
        if (rr3 !== 4'b1000) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 1000", rr3); end
        tick();
        tick();
        rst3_n = 1'b0;
        #1;
        n_tests++;
        if ({rr3, en3, cop3, ca3, cb3, rspv3, rid3, rdat3, rerr3} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got rdy=%b en=%b rspv=%b id=%0d dat=%h err=%b a=%h want all 0",
                     rr3, en3, rspv3, rid3, rdat3, rerr3, ca3);
        end
        tick();
        rst3_n = 1'b1;
        #1;
        n_tests++;
        if ({rspv3, en3, rr3} !== {1'b0, 1'b0, 4'b0001}) begin
            n_fail++;
            $display("FAIL rst_after_grant: got v=%b en=%b rdy=%b want 0 0 0001", rspv3, en3, rr3);
        end
        rv3 = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_lt();
        test_equal();
        test_round_robin();
        test_illegal();
        test_random();
        test_backpressure();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_cmp_sched.md
Name: fp_cmp_sched

Overview:
- Round-robin scheduler sharing one floating-point compare unit (LT/LE/EQ, single-precision IEEE-754) among NREQ requesters.
- Accepts one request at a time and drives the shared comparator's enable and operands. Samples the comparator result after a fixed latency and returns it with the requester ID.
- Sits between the ALU issue logic and the compare datapath; the comparator itself is external.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must be at least clog2(NREQ).
- CMP_LAT, 1, cycles from cmp_en rising to a valid cmp_result (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept (one-hot or zero).
- req_op  input  2*NREQ  per-requester op: 00 LT, 01 LE, 10 EQ, 11 illegal.
- req_a  input  32*NREQ  per-requester operand A (read_data1 role).
- req_b  input  32*NREQ  per-requester operand B (read_data2 role).
- cmp_en  output  1  comparator enable.
- cmp_op  output  2  op to comparator.
- cmp_a  output  32  operand A to comparator.
- cmp_b  output  32  operand B to comparator.
- cmp_result  input  32  comparator output; only bit 0 is used.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  IDW  index of the requester being answered.
- rsp_data  output  32  {31'b0, result}.
- rsp_err  output  1  illegal op flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=NREQ-1, so requester 0 has priority first. All outputs 0: req_ready, cmp_en, cmp_op, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_data, rsp_err. A reset mid-operation abandons the transaction with no response.
- States: IDLE, BUSY, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr+1 with wrap-around.
  - req_ready[grant]=1 combinationally; all other ready bits are 0. No valid means no ready.
  - On the handshake edge: latch op, a, b and grant index; set rr_ptr=grant.
  - If op!=11: go to BUSY, cnt=CMP_LAT.
  - If op==11: go to RESP with rsp_data=0 and rsp_err=1; the comparator is never enabled.
- BUSY:
  - cmp_en=1; cmp_op, cmp_a and cmp_b are driven from the latch and held stable for the whole state.
  - cnt decrements each cycle.
  - On the edge where cnt==1: rsp_data<={31'b0,cmp_result[0]}, rsp_err<=0, go to RESP.
  - BUSY therefore lasts exactly CMP_LAT cycles.
  - cmp_en=0 in every other state; cmp_a, cmp_b and cmp_op hold their last values.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err stay stable until rsp_ready=1.
  - On the handshake edge: go to IDLE, rsp_valid=0.
  - No grant in the same cycle, so minimum spacing is CMP_LAT+2 cycles per request.
- req_ready is 0 in BUSY and RESP. Requests arriving then wait; requesters must hold valid and data stable until ready.
- Simultaneous requests: exactly one grant per IDLE cycle. A continuously asserting requester is served at most once per NREQ grants while others wait (fairness).
- rsp_data is never X: when cmp_result[31:1] is nonzero, those bits are ignored.

Test Plan:
- Single LT request, CMP_LAT=1, bench comparator model:
  - req0: a=0xC1433333 (-12.2), b=0x41600000 (14), op=00.
  - Required: cmp_en high 1 cycle with those operands; rsp_valid 2 cycles after the handshake; rsp_id=0, rsp_data=1, rsp_err=0.
- Equal operands:
  - req2: a=b=0x40200000 (2.5), op 00 -> rsp_data=0.
  - Same operands, op 01 -> rsp_data=1.
  - Same operands, op 10 -> rsp_data=1.
- Round-robin with all four valid continuously, each with a=0x42000000 (32), b=0x43340000 (180), op 00:
  - Grant order 0,1,2,3,0.
  - Every rsp_data=1, with rsp_id matching the grant order.
- Illegal op: req1 op=11.
  - cmp_en stays 0; rsp_valid next cycle with rsp_err=1, rsp_data=0, rsp_id=1.
- Backpressure, CMP_LAT=3:
  - rsp_ready held 0 for 5 cycles.
  - rsp fields stay stable, no req_ready asserted, cmp_en high exactly 3 cycles.
  - After rsp_ready=1, the next grant occurs one cycle later.
- Reset mid-BUSY (CMP_LAT=3): rst_n low in the 2nd BUSY cycle.
  - All outputs 0 immediately, with no response.
  - After release, req0 is granted first when req0 and req3 are both valid.
